fft_pointers_unit: RTL and testbench

- Address/control sequencer for an in-place, radix-2, decimation-in-frequency FFT of N = 2^LOG2N points (default 256).
- Each PROC clock presents one butterfly: the top and bottom data indices and the twiddle-ROM address.
- The FFT datapath uses these to read the dual-port RAM, run the butterfly and write back.
- Input is consumed in natural order; output is left in bit-reversed order.

---
 rtl/fft_pointers_unit.sv | 104 ++++++++++
 tb/tb_fft_pointers_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fft_pointers_unit.sv
// fft_pointers_unit
//   Address/control sequencer for an in-place radix-2 DIF FFT of N = 2^LOG2N
//   points. Each PROC cycle presents one butterfly: top/bottom data indices
//   and the twiddle exponent. Input is consumed in natural order, and the
//   result is left in bit-reversed order.
// Ports:
//   Clk, Reset (async, active low)
//   Start   : begin a transform (sampled in IDLE only)
//   Ack     : acknowledge completion (sampled in DONE only)
//   address : twiddle exponent k << s
//   i_top   : top operand index
//   i_bot   : bottom operand index (i_top + h)
//   Done    : high while in DONE
//   state   : one-hot state {INIT, IDLE, PROC, DONE}
module fft_pointers_unit #(
  parameter int LOG2N = 8,
  parameter int AW    = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  output logic [AW-1:0] address,
  output logic [AW-1:0] i_top,
  output logic [AW-1:0] i_bot,
  output logic          Done,
  output logic [3:0]    state
);

  localparam int N  = 1 << LOG2N;
  localparam int BW = LOG2N - 1;                          // b spans 0..N/2-1
  localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;    // s spans 0..LOG2N-1
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [AW:0]   ONE    = (AW+1)'(1);

  typedef enum logic [3:0] {
    INIT = 4'b1000,
    IDLE = 4'b0100,
    PROC = 4'b0010,
    DONE = 4'b0001
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INIT;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = '0;
    b_d     = '0;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: if (Start) state_d = PROC;
      PROC: begin
        if (b_q != B_LAST) begin
          b_d = b_q + BW'(1);
          s_d = s_q;
        end else if (s_q != S_LAST) begin
          s_d = s_q + SW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: if (Ack) state_d = IDLE;
      // Any non-legal encoding falls back to INIT.
      default: state_d = INIT;
    endcase
  end

  // Index arithmetic, one bit wider than AW so N itself is representable.
  // With h = N >> (s+1) and mask = h-1: k = b & mask, and g*2h is just the
  // group bits of b shifted up by one, so i_top = ((b & ~mask) << 1) | k.
  logic [AW:0] h_w, mask_w, b_w, k_w, top_w, bot_w, addr_w;

  always_comb begin
    h_w    = (AW+1)'(N) >> (32'(s_q) + 1);
    mask_w = h_w - ONE;
    b_w    = (AW+1)'(b_q);
    k_w    = b_w & mask_w;
    top_w  = ((b_w & ~mask_w) << 1) | k_w;
    bot_w  = top_w + h_w;
    addr_w = k_w << s_q;
  end

  assign i_top   = top_w[AW-1:0];
  assign i_bot   = bot_w[AW-1:0];
  assign address = addr_w[AW-1:0];
  assign Done    = (state_q == DONE);
  assign state   = state_q;

endmodule

// File: tb/tb_fft_pointers_unit.sv
// Bench for fft_pointers_unit: a transaction-level model (expected butterfly
// list built by a plain DIF loop nest, plus a PROC-cycle counter) is compared
// against the DUT on every falling clock edge under randomized Start/Ack.
module tb_fft_pointers_unit;

  localparam int LOG2N = 8;
  localparam int AW    = 10;
  localparam int N     = 1 << LOG2N;
  localparam int TOTAL = (N / 2) * LOG2N;

  localparam logic [3:0] S_INIT = 4'b1000;
  localparam logic [3:0] S_IDLE = 4'b0100;
  localparam logic [3:0] S_PROC = 4'b0010;
  localparam logic [3:0] S_DONE = 4'b0001;

  logic          Clk, Reset, Start, Ack;
  logic [AW-1:0] address, i_top, i_bot;
  logic          Done;
  logic [3:0]    state;

  fft_pointers_unit #(.LOG2N(LOG2N), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .address(address), .i_top(i_top), .i_bot(i_bot),
    .Done(Done), .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference butterfly list in execution order: stage, group, offset.
  int  tbl_top [TOTAL];
  int  tbl_bot [TOTAL];
  int  tbl_adr [TOTAL];
  bit  tbl_ready = 1'b0;

  task automatic build_table();
    int idx = 0;
    for (int s = 0; s < LOG2N; s++) begin
      int h = N >> (s + 1);
      for (int base = 0; base < N; base += 2 * h)
        for (int j = 0; j < h; j++) begin
          tbl_top[idx] = base + j;
          tbl_bot[idx] = base + j + h;
          tbl_adr[idx] = j * (N / (2 * h));
          idx++;
        end
    end
  endtask

  task automatic pin(input int idx, input int t, input int bt, input int a);
    chk($sformatf("model_top[%0d]", idx), tbl_top[idx], t);
    chk($sformatf("model_bot[%0d]", idx), tbl_bot[idx], bt);
    chk($sformatf("model_adr[%0d]", idx), tbl_adr[idx], a);
  endtask

  // Transaction-level model: which phase we are in and how many butterflies
  // of the current transform have already been issued.
  logic [3:0] m_st;
  int         m_cnt;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_st  <= S_INIT;
      m_cnt <= 0;
    end else begin
      case (m_st)
        S_INIT: m_st <= S_IDLE;
        S_IDLE: if (Start) begin m_st <= S_PROC; m_cnt <= 0; end
        S_PROC: begin
          if (m_cnt == TOTAL - 1) begin m_st <= S_DONE; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        S_DONE: if (Ack) m_st <= S_IDLE;
        default: m_st <= S_INIT;
      endcase
    end
  end

  task automatic compare_all(input string tag);
    int et, eb, ea;
    if (m_st == S_PROC) begin
      et = tbl_top[m_cnt]; eb = tbl_bot[m_cnt]; ea = tbl_adr[m_cnt];
    end else begin
      et = 0; eb = N / 2; ea = 0;
    end
    chk({tag, "_state"}, state, m_st);
    chk({tag, "_done"},  Done, (m_st == S_DONE));
    chk({tag, "_i_top"}, i_top, et);
    chk({tag, "_i_bot"}, i_bot, eb);
    chk({tag, "_addr"},  address, ea);
  endtask

  always @(negedge Clk) if (tbl_ready) compare_all("cyc");

  task automatic run_xform(input bit do_ack);
    bit seen = 1'b0;
    @(negedge Clk); Start = 1'b1; Ack = 1'b0;
    for (int c = 0; c < TOTAL + 20; c++) begin
      @(negedge Clk);
      if (Done) begin seen = 1'b1; break; end
      Start = 1'($urandom); Ack = 1'($urandom);
    end
    if (!seen) chk("done_timeout", 32'(Done), 32'd1);
    // Hold in DONE with Start asserted and no Ack.
    Ack = 1'b0; Start = 1'b1;
    repeat (50) @(negedge Clk);
    Start = 1'b0;
    if (do_ack) begin
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0;
    build_table();
    pin(0,   0,   128, 0);
    pin(5,   5,   133, 5);
    pin(128, 0,   64,  0);
    pin(129, 1,   65,  2);
    pin(128 + 64, 128, 192, 0);
    pin(256 + 33, 65,  97,  4);
    pin(896, 0,   1,   0);
    pin(1023, 254, 255, 0);
    tbl_ready = 1'b1;

    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1 compare_all("rel");
    chk("rel_state_lit", state, S_INIT);

    repeat (5) @(negedge Clk) begin Start = 1'b0; Ack = 1'($urandom); end
    Ack = 1'b0;

    run_xform(1'b1);
    repeat (3) @(negedge Clk);
    run_xform(1'b1);

    // Abort mid-transform with an asynchronous reset.
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (499) @(negedge Clk) begin Start = 1'($urandom); Ack = 1'($urandom); end
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("abort_state", state, S_INIT);
    chk("abort_top",   i_top, 0);
    chk("abort_bot",   i_bot, N / 2);
    chk("abort_addr",  address, 0);
    chk("abort_done",  32'(Done), 0);
    @(negedge Clk); #2 Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    repeat (4) @(negedge Clk);

    // Free-running random Start/Ack.
    repeat (3000) @(negedge Clk) begin
      Start = ($urandom % 8 == 0);
      Ack   = ($urandom % 16 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
